// File: rtl/sbox_share_arbiter.sv
// Time-shares one combinational S-box between a data-round and a key-schedule requester.
// Define SBOX_ARB_KEY_PRIO_EN to give the key requester fixed priority on ties.
module sbox_share_arbiter #(
    parameter int D_BYTES = 16,
    parameter int K_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 d_req,
    input  logic [8*D_BYTES-1:0] d_in,
    output logic [8*D_BYTES-1:0] d_out,
    output logic                 d_done,
    input  logic                 k_req,
    input  logic [8*K_BYTES-1:0] k_in,
    output logic [8*K_BYTES-1:0] k_out,
    output logic                 k_done,
    output logic [7:0]           sb_addr,
    input  logic [7:0]           sb_data,
    output logic                 busy
);

    localparam int MAXB = (D_BYTES > K_BYTES) ? D_BYTES : K_BYTES;
    localparam int CW   = (MAXB > 1) ? $clog2(MAXB) : 1;
    localparam logic [CW-1:0] D_LAST = CW'(D_BYTES - 1);
    localparam logic [CW-1:0] K_LAST = CW'(K_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        D_RUN,
        K_RUN,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [8*MAXB-1:0]    op_q, op_d;
    logic [8*D_BYTES-1:0] d_out_q, d_out_d;
    logic [8*K_BYTES-1:0] k_out_q, k_out_d;
    logic                 d_done_q, d_done_d;
    logic                 k_done_q, k_done_d;
    logic                 grant_k;
    logic                 running;
    logic [7:0]           cur_byte;

`ifdef SBOX_ARB_KEY_PRIO_EN
    assign grant_k = k_req;
`else
    logic last_k_q, last_k_d;

    // On a tie the side that did not win last time gets the S-box.
    assign grant_k = k_req & (~d_req | ~last_k_q);

    always_comb begin
        last_k_d = last_k_q;
        if (state_q == IDLE && (d_req || k_req)) begin
            last_k_d = grant_k;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_k_q <= 1'b1;
        end else begin
            last_k_q <= last_k_d;
        end
    end
`endif

    assign running  = (state_q == D_RUN) || (state_q == K_RUN);
    assign cur_byte = op_q[8*int'(cnt_q) +: 8];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        d_out_d = d_out_q;
        k_out_d = k_out_q;
        unique case (state_q)
            IDLE: begin
                if (grant_k) begin
                    op_d                 = '0;
                    op_d[8*K_BYTES-1:0]  = k_in;
                    cnt_d                = '0;
                    state_d              = K_RUN;
                end else if (d_req) begin
                    op_d                 = '0;
                    op_d[8*D_BYTES-1:0]  = d_in;
                    cnt_d                = '0;
                    state_d              = D_RUN;
                end
            end
            D_RUN: begin
                d_out_d[8*int'(cnt_q) +: 8] = sb_data;
                if (cnt_q == D_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            K_RUN: begin
                k_out_d[8*int'(cnt_q) +: 8] = sb_data;
                if (cnt_q == K_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Done flags are registered alongside the DONE transition so they cover that cycle only.
    assign d_done_d = (state_q == D_RUN) && (state_d == DONE);
    assign k_done_d = (state_q == K_RUN) && (state_d == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            d_out_q  <= '0;
            k_out_q  <= '0;
            d_done_q <= 1'b0;
            k_done_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            d_out_q  <= d_out_d;
            k_out_q  <= k_out_d;
            d_done_q <= d_done_d;
            k_done_q <= k_done_d;
        end
    end

    assign d_out   = d_out_q;
    assign k_out   = k_out_q;
    assign d_done  = d_done_q;
    assign k_done  = k_done_q;
    assign busy    = (state_q != IDLE);
    assign sb_addr = running ? cur_byte : 8'h00;

endmodule
